// File: rtl/multicycle_control.sv
// Multi-cycle main controller for the 16-bit CPU: Moore FSM walking fetch/decode/
// execute/memory/write-back and driving the datapath enables and ALUOp.
module multicycle_control (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCSource,
    output logic [1:0] ALUOp,
    output logic [3:0] state,
    output logic       illegal,
    output logic       halted
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        WB_I   = 4'd8,
        WB_MEM = 4'd9,
        BRANCH = 4'd10,
        HALT   = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LW, C_SW, C_BEQ, C_HALT, C_ILL
    } cls_t;

    state_t cur;
    cls_t   cls;

    always_comb begin
        case (opcode)
            4'b0000, 4'b0001, 4'b0010: cls = C_R;
            4'b1001, 4'b1010, 4'b1011: cls = C_I;
            4'b1100:                   cls = C_LW;
            4'b1101:                   cls = C_SW;
            4'b1110:                   cls = C_BEQ;
            4'b1111:                   cls = C_HALT;
            default:                   cls = C_ILL;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cur <= FETCH;
        end else begin
            case (cur)
                FETCH:  if (mem_ready) cur <= DECODE;
                DECODE: begin
                    case (cls)
                        C_R:         cur <= EXEC_R;
                        C_I:         cur <= EXEC_I;
                        C_LW, C_SW:  cur <= ADDR;
                        C_BEQ:       cur <= BRANCH;
                        C_HALT:      cur <= HALT;
                        default:     cur <= FETCH;
                    endcase
                end
                EXEC_R: cur <= WB_R;
                EXEC_I: cur <= WB_I;
                ADDR:   cur <= (cls == C_LW) ? MEM_RD : MEM_WR;
                MEM_RD: if (mem_ready) cur <= WB_MEM;
                MEM_WR: if (mem_ready) cur <= FETCH;
                HALT:   cur <= HALT;
                default: cur <= FETCH;
            endcase
        end
    end

    assign state = cur;

    // Decoded from the registered state; only the ready/Zero qualifiers are
    // same-cycle, and reset gates everything so strobes drop immediately.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 1'b0;
        ALUOp       = 2'b00;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                illegal = (cls == C_ILL);
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = (opcode == 4'b0010) ? 2'b11 : 2'b10;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            WB_I:   RegWrite = 1'b1;
            WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 1'b1;
                PCWriteCond = 1'b1;
                PCWrite     = Zero;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
        if (!Resetn) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            MemtoReg    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            PCSource    = 1'b0;
            ALUOp       = 2'b00;
            illegal     = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main controller for the 16-bit CPU. It decodes the 4-bit opcode of the fetched instruction and walks a Moore state machine through fetch, decode, execute, memory and write-back. Each step drives the datapath enables and the 2-bit ALUOp consumed by the ALU control unit. It sits between the instruction register and the datapath, and stalls on a single-ready memory handshake.

## Interface
- No parameters; widths are fixed by the 16-bit ISA (4-bit opcode, 2-bit funct).
- Clock  in  1  single system clock; all state changes on rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- opcode  in  4  instruction bits [15:12], valid from DECODE onward (IR output).
- Zero  in  1  ALU zero flag, sampled in BRANCH.
- mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by Zero (gating done internally; see Operation).
- IRWrite  out  1  instruction register load.
- MemRead, MemWrite  out  1 each  memory request strobes, held until mem_ready.
- IorD  out  1  0 = address from PC, 1 = address from ALUOut.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  0 = rt field, 1 = rd field.
- MemtoReg  out  1  0 = ALUOut, 1 = MDR.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 1, 10 = sign-extended imm, 11 = branch offset.
- PCSource  out  1  0 = ALU result, 1 = ALUOut.
- ALUOp  out  2  00 add, 01 sub/compare, 10 R-format (funct decides), 11 I-format (opcode decides).
- state  out  4  current state encoding, for debug and the bench.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- halted  out  1  high while in HALT.

## Operation
- Opcode map: 0000, 0001 = R-format (EXEC_R, ALUOp 10); 0010 = shift (EXEC_R, ALUOp 11); 1001 ADDI, 1010 SUBI, 1011 SLTI (EXEC_I, ALUOp 11); 1100 LW; 1101 SW; 1110 BEQ; 1111 HALT. All others are illegal.
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BRANCH 10, HALT 11.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=0.
  - IRWrite = PCWrite = mem_ready, so the PC and IR load only on the ready cycle.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target into ALUOut).
  - Next state by opcode: R/shift -> EXEC_R; ADDI/SUBI/SLTI -> EXEC_I; LW/SW -> ADDR; BEQ -> BRANCH; HALT -> HALT; illegal -> FETCH with illegal=1 for this cycle.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp 10 (or 11 for opcode 0010) -> WB_R.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> WB_I.
- ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: IorD=1, MemRead=1; stay until mem_ready, then -> WB_MEM.
- MEM_WR: IorD=1, MemWrite=1; stay until mem_ready, then -> FETCH.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
- WB_MEM: RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWriteCond=1, PCWrite = Zero -> FETCH.
- HALT: all strobes 0, halted=1; left only by reset.
- Outputs not listed for a state are 0.
- Outputs are decoded from state only, except the mem_ready and Zero qualifiers listed above.

## Timing
- While Resetn=0: state=FETCH and every output is forced to 0 (state reads 0).
  - FETCH strobes assert in the first cycle after release.
- Reset asserted mid-instruction aborts it immediately. There is no partial write-back, and any pending MemRead/MemWrite drops in the same cycle.
- Latency with zero-wait memory (mem_ready=1 every cycle): BEQ 3, R/I/SW 4, LW 5 cycles. Each mem_ready=0 cycle adds exactly one cycle in FETCH, MEM_RD or MEM_WR.
- MemRead/MemWrite/IorD remain stable throughout a wait; no strobe toggles during a stall.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- The illegal pulse is exactly one cycle, coincident with DECODE.

## Test plan
- Reset then opcode 0000, mem_ready=1 -> state sequence 0,1,2,7,0; RegWrite=1 and RegDst=1 only in state 7; ALUOp=10 in state 2.
- LW (1100) with mem_ready low for 2 cycles in MEM_RD -> sequence 0,1,4,5,5,5,9,0; MemRead and IorD=1 held across the wait; MemtoReg=1 in state 9.
- BEQ (1110) with Zero=1, then with Zero=0 -> PCWrite=1 vs 0 in state 10; ALUOp=01; 3 cycles total each.
- Opcode 0101 -> illegal=1 for one cycle in DECODE, next state FETCH, no RegWrite/MemWrite asserted.
- SW (1101): Resetn pulled low during MEM_WR -> MemWrite drops in that cycle; after release state=0 and MemRead=1.
- HALT (1111) -> state 11, halted=1 and held for 20 cycles regardless of mem_ready; reset returns to FETCH.
